register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
Parametrised integer register file: NUM_REGS entries of XLEN bits, two combinational read ports and one write port. It has optional x0-hardwired-zero and optional write-to-read bypass. The block has no per-entry reset. Storage is zeroed by a built-in scrub sequencer, which runs after reset and on request. It sits in the central processing unit between decode (read ports) and writeback (write port).

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, number of registers (2..64)
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read port

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
rd0_addr  input  ADDR_W  read port 0 address
rd0_data  output  XLEN  read port 0 data (combinational)
rd1_addr  input  ADDR_W  read port 1 address
rd1_data  output  XLEN  read port 1 data (combinational)
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  XLEN  write data
clr  input  1  request a full scrub (single-cycle pulse, level also accepted)
wr_ready  output  1  write accepted this cycle
busy  output  1  scrub in progress

Behaviour:
- Reset: one clock; rst is synchronous and active-low.
  - rst=0 at a rising edge: state<=CLEAR, ptr<=0. Storage contents are untouched.
  - While rst=0: busy=1, wr_ready=0, rd0_data=rd1_data=0.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to entry ptr, then ptr<=ptr+1.
  - In the cycle with ptr==NUM_REGS-1, that entry is written to 0 and state<=IDLE.
  - busy=1 for exactly NUM_REGS cycles after the first cycle with rst=1.
  - IDLE: busy=0. clr=1 → state<=CLEAR, ptr<=0 next edge.
  - clr during CLEAR is ignored; the scrub is not restarted.
  - rst=0 mid-scrub: ptr returns to 0 and the scrub restarts.
- Write port:
  - wr_ready = (state==IDLE) & ~clr & rst.
  - Write occurs at the edge when wr_en & wr_ready and wr_addr < NUM_REGS and !(ZERO_REG & wr_addr==0).
  - Otherwise the write is silently dropped. There is no queueing; the requester must hold or retry while wr_ready=0.
  - Write latency: one edge; the value is visible from storage the following cycle.
- Read ports, combinational, evaluated in priority order:
  1. busy=1 or rst=0 → 0.
  2. addr >= NUM_REGS → 0.
  3. ZERO_REG and addr==0 → 0.
  4. BYPASS and the write qualifies this cycle and wr_addr==addr → wr_data.
  5. Otherwise → stored entry.
- Both read ports are independent; the same address on both ports returns identical data.
- BYPASS=0: a read in the write cycle returns the old value.
- ZERO_REG=0: entry 0 is an ordinary register, scrubbed like the others.
- Storage: NUM_REGS x XLEN flops with enable, no reset term. Only the scrub and qualified writes modify them. The NUM_REGS-entry ZERO_REG=1 build need not implement entry 0 flops.
- Post-scrub guarantee: every entry reads 0 until written.

Test Plan:
- Reset release: rst low 3 cycles then high → busy=1 for 32 cycles, wr_ready=0 and reads=0 throughout. In cycle 33, busy=0 and all 32 addresses read 0x0 on both ports.
- Write/read: write 0xDEAD_BEEF_0000_0005 to x5, then 0x1234 to x31 → next cycle rd0(x5) and rd1(x31) return those values. Writing 0xFFFF to x0 → rd0(x0)=0 (ZERO_REG=1). With ZERO_REG=0, the same write reads back 0xFFFF.
- Bypass: in one cycle, write 0xAAAA to x7 with rd0_addr=x7 and rd1_addr=x7 → both read 0xAAAA in that same cycle. With BYPASS=0, the same stimulus returns the old value, then 0xAAAA next cycle.
- Clear collision: in IDLE with x3=0x55, assert clr and wr_en (x3, 0x77) in the same cycle → wr_ready=0, write dropped, busy=1 for 32 cycles. Afterwards x3 reads 0.
- Reset mid-scrub: pulse clr; after 10 scrub cycles assert rst=0 for 1 cycle → scrub restarts at ptr=0. busy stays 1 for 32 cycles after rst release, and all entries read 0 afterwards.
- Parameter sweep: NUM_REGS=16 (ADDR_W=4), XLEN=32 → scrub takes 16 cycles, and write/read of 0xCAFEBABE to x15 works. Separately, NUM_REGS=20: read of addr 25 returns 0 and a write to addr 25 is dropped.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read/one-write integer register file with optional hardwired x0 and write bypass.
// Storage has no reset; a scrub sequencer zeroes every entry after reset and on clr.
module register_file_2r1w #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [XLEN-1:0]   rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [XLEN-1:0]   rd1_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              clr,
  output logic              wr_ready,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [XLEN-1:0]   mem_q [NUM_REGS];
  logic [XLEN-1:0]   mem_d [NUM_REGS];

  logic              scrub_we;
  logic              wr_fire;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [XLEN-1:0]   rd_data_c [2];

  // Non-power-of-two depths leave addresses above NUM_REGS-1 unbacked.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS);
  endfunction

  assign busy     = ~rst | (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE) & ~clr & rst;
  assign scrub_we = rst & (state_q == CLEAR);
  assign wr_fire  = wr_en & wr_ready & addr_ok(wr_addr)
                  & ~(ZERO_REG && (wr_addr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    end else if (clr) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (scrub_we) begin
      mem_d[ptr_q] = '0;
    end else if (wr_fire) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data_c[p] = '0;
      if (busy) begin
        rd_data_c[p] = '0;
      end else if (!addr_ok(rd_addr[p])) begin
        rd_data_c[p] = '0;
      end else if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data_c[p] = '0;
      end else if (BYPASS && wr_fire && (wr_addr == rd_addr[p])) begin
        rd_data_c[p] = wr_data;
      end else begin
        rd_data_c[p] = mem_q[rd_addr[p]];
      end
    end
  end

  assign rd0_data = rd_data_c[0];
  assign rd1_data = rd_data_c[1];

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: default build, a ZERO_REG=0/BYPASS=0 build sharing its
// stimulus, and 16-/20-entry 32-bit builds sharing a second stimulus set.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_en = 1'b0, clr = 1'b0;
  logic [63:0] rd0_data, rd1_data, nb_rd0, nb_rd1;
  logic        wr_ready, busy, nb_ready, nb_busy;

  logic [4:0]  s_ra = '0, s_wa = '0;
  logic [31:0] s_wd = '0;
  logic        s_we = 1'b0;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_ready, a_busy, b_ready, b_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra0, ra1;
    logic [63:0] e0, e1, n0, n1;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  register_file_2r1w u_dut (
    .clk(clk), .rst(rst),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .wr_ready(wr_ready), .busy(busy)
  );

  register_file_2r1w #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst),
    .rd0_addr(rd0_addr), .rd0_data(nb_rd0),
    .rd1_addr(rd1_addr), .rd1_data(nb_rd1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .wr_ready(nb_ready), .busy(nb_busy)
  );

  register_file_2r1w #(.XLEN(32), .NUM_REGS(16)) u_r16 (
    .clk(clk), .rst(rst),
    .rd0_addr(s_ra[3:0]), .rd0_data(a_rd0),
    .rd1_addr(s_ra[3:0]), .rd1_data(a_rd1),
    .wr_en(s_we), .wr_addr(s_wa[3:0]), .wr_data(s_wd),
    .clr(clr), .wr_ready(a_ready), .busy(a_busy)
  );

  register_file_2r1w #(.XLEN(32), .NUM_REGS(20)) u_r20 (
    .clk(clk), .rst(rst),
    .rd0_addr(s_ra), .rd0_data(b_rd0),
    .rd1_addr(s_ra), .rd1_data(b_rd1),
    .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd),
    .clr(clr), .wr_ready(b_ready), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %h expected an entry", act);
    end else begin
      e = sb.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic scrub_window(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rd0_addr = 5'(i);
      rd1_addr = 5'(31 - i);
      #3;
      check($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'd1);
      check($sformatf("%s_rdy%0d", tag, i), 64'(wr_ready), 64'd0);
      check($sformatf("%s_rd0_%0d", tag, i), rd0_data, 64'd0);
      check($sformatf("%s_nbbusy%0d", tag, i), 64'(nb_busy), 64'd1);
      tick();
    end
    #3;
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_nbbusy_end"}, 64'(nb_busy), 64'd0);
    tick();
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd0_addr = 5'(i);
      rd1_addr = 5'(31 - i);
      #3;
      check($sformatf("%s_rd0_x%0d", tag, i), rd0_data, 64'd0);
      check($sformatf("%s_rd1_x%0d", tag, 31 - i), rd1_data, 64'd0);
      check($sformatf("%s_nb_x%0d", tag, i), nb_rd0, 64'd0);
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0000_0005, 5'd5, 5'd31,
                64'hDEAD_BEEF_0000_0005, 64'h0, 64'h0, 64'h0};
    vecs[1] = '{1'b1, 5'd31, 64'h1234, 5'd5, 5'd31,
                64'hDEAD_BEEF_0000_0005, 64'h1234, 64'hDEAD_BEEF_0000_0005, 64'h0};
    vecs[2] = '{1'b1, 5'd0,  64'hFFFF, 5'd5, 5'd31,
                64'hDEAD_BEEF_0000_0005, 64'h1234, 64'hDEAD_BEEF_0000_0005, 64'h1234};
    vecs[3] = '{1'b0, 5'd0,  64'h0, 5'd0, 5'd31, 64'h0, 64'h1234, 64'hFFFF, 64'h1234};
    vecs[4] = '{1'b1, 5'd7,  64'hAAAA, 5'd7, 5'd7, 64'hAAAA, 64'hAAAA, 64'h0, 64'h0};
    vecs[5] = '{1'b0, 5'd0,  64'h0, 5'd7, 5'd0, 64'hAAAA, 64'h0, 64'hAAAA, 64'hFFFF};
    vecs[6] = '{1'b1, 5'd0,  64'h1, 5'd0, 5'd0, 64'h0, 64'h0, 64'hFFFF, 64'hFFFF};
    vecs[7] = '{1'b0, 5'd0,  64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h1, 64'h1};
    vecs[8] = '{1'b1, 5'd3,  64'h55, 5'd3, 5'd5,
                64'h55, 64'hDEAD_BEEF_0000_0005, 64'h0, 64'hDEAD_BEEF_0000_0005};
    vecs[9] = '{1'b0, 5'd3,  64'h99, 5'd3, 5'd3, 64'h55, 64'h55, 64'h55, 64'h55};

    // reset held low for three edges
    for (int i = 0; i < 3; i++) begin
      rd0_addr = 5'd5;
      #3;
      check($sformatf("rst_busy%0d", i), 64'(busy), 64'd1);
      check($sformatf("rst_rdy%0d", i), 64'(wr_ready), 64'd0);
      check($sformatf("rst_rd0_%0d", i), rd0_data, 64'd0);
      tick();
    end
    rst = 1'b1;

    // initial scrub, with the 16- and 20-entry builds finishing earlier
    for (int i = 0; i < 32; i++) begin
      rd0_addr = 5'(i);
      rd1_addr = 5'(31 - i);
      #3;
      check($sformatf("init_busy%0d", i), 64'(busy), 64'd1);
      check($sformatf("init_rdy%0d", i), 64'(wr_ready), 64'd0);
      check($sformatf("init_rd1_%0d", i), rd1_data, 64'd0);
      check($sformatf("r16_busy%0d", i), 64'(a_busy), (i < 16) ? 64'd1 : 64'd0);
      check($sformatf("r20_busy%0d", i), 64'(b_busy), (i < 20) ? 64'd1 : 64'd0);
      tick();
    end
    #3;
    check("init_busy_end", 64'(busy), 64'd0);
    check("init_rdy_end", 64'(wr_ready), 64'd1);
    tick();
    sweep_zero("post_init");

    for (int i = 0; i < 10; i++) begin
      wr_en    = vecs[i].we;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      rd0_addr = vecs[i].ra0;
      rd1_addr = vecs[i].ra1;
      push($sformatf("v%0d_rd0", i), vecs[i].e0);
      push($sformatf("v%0d_rd1", i), vecs[i].e1);
      push($sformatf("v%0d_nb_rd0", i), vecs[i].n0);
      push($sformatf("v%0d_nb_rd1", i), vecs[i].n1);
      push($sformatf("v%0d_rdy", i), 64'd1);
      #3;
      pop_check(rd0_data);
      pop_check(rd1_data);
      pop_check(nb_rd0);
      pop_check(nb_rd1);
      pop_check(64'(wr_ready));
      tick();
    end
    wr_en = 1'b0;

    // clr collides with a write to x3; write held through the scrub
    clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
    rd0_addr = 5'd3; rd1_addr = 5'd3;
    #3;
    check("coll_rdy", 64'(wr_ready), 64'd0);
    check("coll_busy", 64'(busy), 64'd0);
    check("coll_rd0", rd0_data, 64'h55);
    check("coll_nb_rd1", nb_rd1, 64'h55);
    tick();
    for (int i = 0; i < 32; i++) begin
      clr = (i == 5);
      #3;
      check($sformatf("coll_busy%0d", i), 64'(busy), 64'd1);
      check($sformatf("coll_rdy%0d", i), 64'(wr_ready), 64'd0);
      check($sformatf("coll_rd0_%0d", i), rd0_data, 64'd0);
      tick();
    end
    clr = 1'b0; wr_en = 1'b0;
    #3;
    check("coll_busy_end", 64'(busy), 64'd0);
    check("coll_x3", rd0_data, 64'd0);
    check("coll_nb_x3", nb_rd1, 64'd0);
    tick();

    // reset arrives ten cycles into a clr-triggered scrub
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h1111;
    #3;
    check("mid_pre_rdy", 64'(wr_ready), 64'd1);
    tick();
    wr_en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    #3;
    check("mid_rst_busy", 64'(busy), 64'd1);
    check("mid_rst_rdy", 64'(wr_ready), 64'd0);
    check("mid_rst_rd0", rd0_data, 64'd0);
    tick();
    rst = 1'b1;
    scrub_window("mid", 32);
    sweep_zero("post_mid");

    // 16- and 20-entry, 32-bit builds
    s_we = 1'b1; s_wa = 5'd15; s_wd = 32'hCAFE_BABE; s_ra = 5'd15;
    #3;
    check("r16_byp_x15", 64'(a_rd0), 64'hCAFE_BABE);
    check("r20_byp_x15", 64'(b_rd0), 64'hCAFE_BABE);
    tick();
    s_we = 1'b0;
    #3;
    check("r16_x15", 64'(a_rd1), 64'hCAFE_BABE);
    check("r20_x15", 64'(b_rd1), 64'hCAFE_BABE);
    tick();
    s_we = 1'b1; s_wa = 5'd25; s_wd = 32'h5; s_ra = 5'd25;
    #3;
    check("r20_oob_rdy", 64'(b_ready), 64'd1);
    check("r20_oob_byp", 64'(b_rd0), 64'd0);
    tick();
    s_we = 1'b0;
    #3;
    check("r20_oob_rd", 64'(b_rd0), 64'd0);
    check("r16_x9_alias", 64'(a_rd0), 64'h5);
    tick();
    s_ra = 5'd15;
    #3;
    check("r20_x15_kept", 64'(b_rd0), 64'hCAFE_BABE);
    tick();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
